// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_event_ctrl
// Description : 4x4 keypad event controller. It debounces press and release,
//               generates auto-repeat, and queues events in a FIFO that the
//               processor reads over the chip-select bus.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_ctrl #(
    parameter int TICK_DIV = 250_000,
    parameter int DEB_N    = 3,
    parameter int REP_DLY  = 100,
    parameter int REP_PER  = 20,
    parameter int FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_val,
    input  logic        cs,
    input  logic        rd,
    input  logic        addr,
    output logic [15:0] rddata,
    output logic        irq
);
    localparam int c_TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DW    = $clog2(DEB_N + 1);
    localparam int c_RW    = $clog2(REP_DLY + 1);
    localparam int c_CW    = FIFO_AW + 1;
    localparam int c_DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] c_EV_PRESS   = 2'b01;
    localparam logic [1:0] c_EV_REPEAT  = 2'b10;
    localparam logic [1:0] c_EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] idx4(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [c_TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [c_DW-1:0]     dcnt_q, dcnt_d;
    logic [c_RW-1:0]     rcnt_q, rcnt_d;
    logic [3:0]          cand_q, cand_d;
    logic [3:0]          cur_q, cur_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [c_DEPTH];

    logic                w_tick;
    logic                w_is_key;
    logic [3:0]          w_code;
    logic                w_push;
    logic [7:0]          w_push_byte;
    logic                w_pop;
    logic                w_wr;
    logic [3:0]          w_cnt4;

    assign w_tick   = (tick_cnt_q == c_TW'(TICK_DIV - 1));
    assign w_is_key = is_onehot(scan_val[7:4]) && is_onehot(scan_val[3:0]);
    assign w_code   = {idx4(scan_val[7:4]), idx4(scan_val[3:0])};

    always_comb begin
        tick_cnt_d  = w_tick ? '0 : tick_cnt_q + c_TW'(1);
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        cand_d      = cand_q;
        cur_d       = cur_q;
        w_push      = 1'b0;
        w_push_byte = 8'h00;
        if (w_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_is_key) begin
                        cand_d  = w_code;
                        dcnt_d  = c_DW'(1);
                        state_d = S_PRESS_DB;
                    end
                end
                S_PRESS_DB: begin
                    if (w_is_key && (w_code == cand_q)) begin
                        dcnt_d = dcnt_q + c_DW'(1);
                        if (dcnt_q + c_DW'(1) == c_DW'(DEB_N)) begin
                            w_push      = 1'b1;
                            w_push_byte = {c_EV_PRESS, 2'b00, cand_q};
                            cur_d       = cand_q;
                            rcnt_d      = '0;
                            state_d     = S_HELD;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_is_key && (w_code == cur_q)) begin
                        if (rcnt_q == c_RW'(REP_DLY - 1)) begin
                            w_push      = 1'b1;
                            w_push_byte = {c_EV_REPEAT, 2'b00, cur_q};
                            rcnt_d      = c_RW'(REP_DLY - REP_PER);
                        end else begin
                            rcnt_d = rcnt_q + c_RW'(1);
                        end
                    end else begin
                        dcnt_d  = c_DW'(1);
                        state_d = S_REL_DB;
                    end
                end
                S_REL_DB: begin
                    // rcnt is left untouched so a bounce back resumes the repeat timing
                    if (w_is_key && (w_code == cur_q)) begin
                        state_d = S_HELD;
                    end else begin
                        dcnt_d = dcnt_q + c_DW'(1);
                        if (dcnt_q + c_DW'(1) == c_DW'(DEB_N)) begin
                            w_push      = 1'b1;
                            w_push_byte = {c_EV_RELEASE, 2'b00, cur_q};
                            state_d     = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    assign w_pop = cs && rd && !addr && (count_q != '0);
    assign w_wr  = w_push && ((count_q != c_CW'(c_DEPTH)) || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (w_wr ? FIFO_AW'(1) : FIFO_AW'(0));
        rd_ptr_d = rd_ptr_q + (w_pop ? FIFO_AW'(1) : FIFO_AW'(0));
        count_d  = count_q + (w_wr ? c_CW'(1) : c_CW'(0)) - (w_pop ? c_CW'(1) : c_CW'(0));
        ovf_d    = ovf_q;
        if (cs && rd && addr) ovf_d = 1'b0;
        if (w_push && !w_wr)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            dcnt_q     <= '0;
            rcnt_q     <= '0;
            cand_q     <= '0;
            cur_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            dcnt_q     <= dcnt_d;
            rcnt_q     <= rcnt_d;
            cand_q     <= cand_d;
            cur_q      <= cur_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) mem_q[wr_ptr_q] <= w_push_byte;
    end

    assign w_cnt4 = 4'(count_q);

    always_comb begin
        rddata = 16'h0000;
        if (cs) begin
            if (!addr) begin
                if (count_q != '0) rddata = {8'h00, mem_q[rd_ptr_q]};
            end else begin
                rddata = {ovf_q, 11'b0, w_cnt4};
            end
        end
    end

    assign irq = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_ctrl
// Description : Scoreboard bench for key_event_ctrl with directed keypad
//               scenarios; a monitor pops expectations on every observed read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;
    localparam int TICK_DIV = 4;
    localparam int DEB_N    = 3;
    localparam int REP_DLY  = 5;
    localparam int REP_PER  = 2;
    localparam int FIFO_AW  = 3;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  scan_val = 8'h00;
    logic        cs       = 1'b0;
    logic        rd       = 1'b0;
    logic        addr     = 1'b0;
    logic [15:0] rddata;
    logic        irq;

    logic        chk_irq  = 1'b0;
    logic        end_chk  = 1'b0;
    int          cyc      = 0;
    int          n_run    = 0;
    int          n_fail   = 0;

    typedef struct {
        bit          is_irq;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    key_event_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DEB_N    (DEB_N),
        .REP_DLY  (REP_DLY),
        .REP_PER  (REP_PER),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_val (scan_val),
        .cs       (cs),
        .rd       (rd),
        .addr     (addr),
        .rddata   (rddata),
        .irq      (irq)
    );

    // Sample-tick phase reference: tick falls in cycles where cyc % TICK_DIV == TICK_DIV-1
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if ((cs && rd) || chk_irq) begin
            exp_t        e;
            logic [15:0] act;
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h, no expectation queued", rddata);
            end else begin
                e   = exp_q.pop_front();
                act = e.is_irq ? {15'd0, irq} : rddata;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
        if (end_chk) begin
            n_run++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] v, input int ticks);
        scan_val = v;
        repeat (ticks * TICK_DIV) cycle();
    endtask

    task automatic bus_read(input logic a, input logic [15:0] e, input string nm);
        exp_t x;
        x.is_irq = 1'b0;
        x.exp    = e;
        x.name   = nm;
        exp_q.push_back(x);
        cs = 1'b1; rd = 1'b1; addr = a;
        cycle();
        cs = 1'b0; rd = 1'b0; addr = 1'b0;
    endtask

    task automatic irq_probe(input logic e, input string nm);
        exp_t x;
        x.is_irq = 1'b1;
        x.exp    = {15'd0, e};
        x.name   = nm;
        exp_q.push_back(x);
        chk_irq = 1'b1;
        cycle();
        chk_irq = 1'b0;
    endtask

    logic [15:0] rep_ev [6] = '{16'h004E, 16'h008E, 16'h008E, 16'h008E, 16'h008E, 16'h00CE};
    logic [15:0] ovf_ev [7] = '{16'h00C1, 16'h0042, 16'h00C2, 16'h0043, 16'h00C3, 16'h0046, 16'h00C6};
    logic [7:0]  ovf_key [4] = '{8'h11, 8'h12, 8'h14, 8'h18};

    initial begin
        // Reset with a key present
        rst = 1'b1;
        scan_val = 8'h21;
        cycle();
        irq_probe(1'b0, "rst_irq");
        rst = 1'b0;
        hold(8'h21, 2);
        scan_val = 8'h00;
        irq_probe(1'b0, "post_rst_irq");
        bus_read(1'b1, 16'h0000, "post_rst_status");
        bus_read(1'b0, 16'h0000, "post_rst_event");
        hold(8'h00, 2);

        // Clean press and release
        hold(8'h21, 3);
        hold(8'h00, 3);
        irq_probe(1'b1, "clean_irq_high");
        bus_read(1'b1, 16'h0002, "clean_status");
        bus_read(1'b0, 16'h0044, "clean_press");
        bus_read(1'b0, 16'h00C4, "clean_release");
        irq_probe(1'b0, "clean_irq_low");
        bus_read(1'b0, 16'h0000, "pop_empty");

        // Bounce never reaches DEB_N
        hold(8'h21, 1);
        hold(8'h00, 1);
        hold(8'h21, 2);
        hold(8'h00, 2);
        bus_read(1'b1, 16'h0000, "bounce_status");
        irq_probe(1'b0, "bounce_irq");

        // Two rows active
        hold(8'h31, 10);
        hold(8'h00, 1);
        bus_read(1'b1, 16'h0000, "multi_status");

        // Auto-repeat
        hold(8'h84, 3);
        hold(8'h84, 12);
        hold(8'h00, 3);
        bus_read(1'b1, 16'h0006, "repeat_status");
        for (int i = 0; i < 6; i++) bus_read(1'b0, rep_ev[i], $sformatf("repeat_ev%0d", i));
        irq_probe(1'b0, "repeat_irq_low");

        // Overflow: 8 stored events, then a press/release pair that is dropped
        for (int i = 0; i < 4; i++) begin
            hold(ovf_key[i], 3);
            hold(8'h00, 3);
        end
        hold(8'h22, 3);
        hold(8'h00, 3);
        bus_read(1'b1, 16'h8008, "ovf_status");
        bus_read(1'b1, 16'h0008, "ovf_cleared");
        irq_probe(1'b1, "ovf_irq");
        bus_read(1'b0, 16'h0040, "ovf_ev0");
        bus_read(1'b0, 16'h00C0, "ovf_ev1");

        // Land a pop on the exact tick cycle that pushes the PRESS of key 0x24
        while ((cyc % TICK_DIV) != 0) cycle();
        scan_val = 8'h24;
        repeat (3 * TICK_DIV - 1) cycle();
        bus_read(1'b0, 16'h0041, "simul_pop");
        scan_val = 8'h00;
        bus_read(1'b1, 16'h0006, "simul_status");
        hold(8'h00, 3);
        bus_read(1'b1, 16'h0007, "after_release_status");
        for (int i = 0; i < 7; i++) bus_read(1'b0, ovf_ev[i], $sformatf("order_ev%0d", i));
        irq_probe(1'b0, "final_irq");
        bus_read(1'b1, 16'h0000, "final_status");

        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_ctrl.md
# key_event_ctrl

Event controller for the 4x4 matrix keypad. It samples the scanner's 8-bit row/column value on a fixed tick and debounces press and release. It generates press, auto-repeat and release events and queues them in an 8-entry FIFO. The processor reads the FIFO through the same chip-select bus slot the scanner uses, with a level interrupt that stays asserted while events are pending.

## Interface
- TICK_DIV, 250_000: clk cycles per sample tick (5 ms at 50 MHz)
- DEB_N, 3: consecutive identical samples needed to accept a press or a release (≥2)
- REP_DLY, 100: ticks from the press event to the first repeat event
- REP_PER, 20: ticks between later repeat events (1 ≤ REP_PER ≤ REP_DLY)
- FIFO_AW, 3: FIFO address width, so depth is 2^FIFO_AW = 8
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- scan_val  in  8  {row[3:0], col[3:0]}, active-high key lines from the scanner, clk domain
- cs  in  1  bus chip select
- rd  in  1  read strobe, qualified by cs
- addr  in  1  0 = event pop, 1 = status
- rddata  out  16  read data; 16'h0000 whenever cs=0
- irq  out  1  high while the FIFO is non-empty

## Operation
- Tick counter
  - Counts 0..TICK_DIV-1.
  - tick=1 for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.
  - The FSM and debounce/repeat counters change only on tick cycles.
- Sample classification on each tick:
  - NONE: either nibble is zero.
  - KEY(c): both nibbles are one-hot. c = {row_idx[1:0], col_idx[1:0]}, where each idx is the bit position inside its nibble.
  - MULTI: any other value.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB.
  - IDLE, KEY(c): cand←c, dcnt←1, go to PRESS_DB. NONE or MULTI: stay in IDLE.
  - PRESS_DB, KEY(cand): dcnt++. When dcnt reaches DEB_N: push PRESS(cand), cur←cand, rcnt←0, go to HELD.
  - PRESS_DB, any other sample: go to IDLE, no event.
  - HELD, KEY(cur):
    - If rcnt==REP_DLY-1: push REPEAT(cur), rcnt←REP_DLY-REP_PER.
    - Otherwise rcnt++.
  - HELD, any other sample (NONE, MULTI or a different key): dcnt←1, go to REL_DB.
  - REL_DB, sample ≠ KEY(cur): dcnt++. When dcnt reaches DEB_N: push RELEASE(cur), go to IDLE. A different key is then seen as a fresh press from IDLE.
  - REL_DB, KEY(cur): go back to HELD. rcnt is frozen in REL_DB and resumes from its held value.
- Event byte: {type[1:0], 2'b00, code[3:0]}.
  - type: 01 = press, 10 = repeat, 11 = release.
  - type 00 never appears in a stored event.
- FIFO
  - Push when full: the event is dropped and the sticky overflow flag is set.
  - Push and pop in the same cycle: both take effect; count is unchanged.
  - Pop when empty: no effect and the read returns 16'h0000. A same-cycle push into the empty FIFO is still stored.
- Reads (combinational rddata)
  - cs & addr=0: {8'h00, head event byte}, or 16'h0000 when empty.
  - cs & addr=1: {overflow, 11'b0, count[3:0]}, count in 0..8.
  - A pop occurs at the clock edge ending a cycle with cs & rd & addr=0. Holding rd high pops once per cycle, so the bus master pulses rd for one cycle per read.
  - The overflow flag clears at the edge ending a cycle with cs & rd & addr=1. An overflow occurring in that same cycle wins, and the flag stays 1.
- irq = (count != 0), derived from the registered count only.

## Timing
- Reset values:
  - Tick counter 0; FSM in IDLE.
  - dcnt, rcnt, cand, cur all 0.
  - FIFO empty, count 0, overflow 0, irq 0.
  - rddata 16'h0000 for any access.
- Reset applied mid-debounce or mid-hold aborts the sequence with no event. Queued events are discarded.
- Press latency:
  - The PRESS event is pushed on the DEB_N-th consecutive KEY tick.
  - irq rises and the head event becomes readable in the cycle after that tick edge.
- First REPEAT comes REP_DLY ticks after the press tick; later repeats follow every REP_PER ticks of continuous hold.
- RELEASE is pushed on the DEB_N-th consecutive non-matching tick.
- After a pop, rddata shows the new head in the next cycle. irq falls in the cycle after the pop that empties the FIFO.

## Test plan
All scenarios use TICK_DIV=4, DEB_N=3, REP_DLY=5, REP_PER=2.
- Reset: assert rst for 2 cycles with scan_val=8'h21 present -> irq=0, status read 16'h0000, event read 16'h0000, no event within 2 ticks after release of rst.
- Clean press: scan_val=8'h21 for 3 ticks, then 8'h00 for 3 ticks -> pop gives 16'h0044, then 16'h00C4; irq=0 afterwards.
- Bounce: 8'h21 for 1 tick, 8'h00 for 1 tick, 8'h21 for 2 ticks, then 8'h00 -> no event; status 16'h0000.
- Multi-key: 8'h31 for 10 ticks -> no event.
- Auto-repeat: 8'h84 held for 3 ticks (press event), then 12 more ticks -> events read in order 16'h004E, then 16'h008E ×4, and after release debounce 16'h00CE.
- Overflow and simultaneity: generate 9 events without reading -> status 16'h8008, 9th event lost. Status read -> 16'h0008 on the next read. Pop in the same cycle as a push -> count unchanged, order preserved.
